c17_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for the c17 combinational benchmark.
- Drives all 2^NUM_IN input vectors into c17 in ascending binary order, waits a settle interval for each, and captures c17's outputs into a MISR signature.
- Compares the final signature against a golden value and reports pass/fail.
- Sits between the lab top level (start/status) and the c17 instance, which it drives directly.

---
 rtl/c17_bist_pkg.sv | 24 ++
 rtl/c17_misr.sv | 33 +++
 rtl/c17_bist_ctrl.sv | 104 ++++++++++
 tb/tb_c17_bist_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST sequencer and its MISR.
package c17_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETTLE  = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_FINISH  = 2'b11
    } bist_state_t;

    localparam int          DEF_SIG_W    = 16;
    localparam logic [15:0] DEF_POLY     = 16'h1021;
    localparam int          SETTLE_CNT_W = 4;

    // Bit positions of the c17 pins inside vec_out / resp_in.
    localparam int VEC_N1   = 0;
    localparam int VEC_N2   = 1;
    localparam int VEC_N3   = 2;
    localparam int VEC_N6   = 3;
    localparam int VEC_N7   = 4;
    localparam int RESP_N22 = 0;
    localparam int RESP_N23 = 1;

endpackage

// File: rtl/c17_misr.sv
// Multiple-input signature register compacting the c17 response stream.
module c17_misr
    import c17_bist_pkg::*;
#(
    parameter int             SIG_W = DEF_SIG_W,
    parameter int             DIN_W = 2,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] feedback;

    assign feedback = sig[SIG_W-1] ? POLY : '0;

    // Clear takes priority so a new run always starts from SEED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (clear) begin
            sig <= SEED;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ feedback ^ SIG_W'(din);
        end
    end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST sequencer: sweeps every c17 input vector, compacts the responses
// into a MISR and compares the final signature against a golden value.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int               NUM_IN     = 5,
    parameter int               NUM_OUT    = 2,
    parameter int               SIG_W      = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED       = '0,
    parameter int               SETTLE     = 1,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [NUM_IN-1:0]  vec_out,
    input  logic [NUM_OUT-1:0] resp_in,
    output logic [NUM_IN-1:0]  vec_idx,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [SIG_W-1:0]   signature
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE);
    localparam logic [NUM_IN-1:0]       LAST_VEC    = '1;

    bist_state_t             state;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic                    misr_clear;
    logic                    misr_en;

    assign misr_clear = (state == ST_IDLE) && start;
    assign misr_en    = (state == ST_CAPTURE);
    assign vec_out    = vec_idx;

    c17_misr #(
        .SIG_W (SIG_W),
        .DIN_W (NUM_OUT),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear (misr_clear),
        .en    (misr_en),
        .din   (resp_in),
        .sig   (signature)
    );

    // The MISR shifts on the same edge that leaves CAPTURE, so FINISH
    // already sees the signature including the last vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec_idx    <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        vec_idx    <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (vec_idx == LAST_VEC) begin
                        state <= ST_FINISH;
                    end else begin
                        vec_idx    <= vec_idx + NUM_IN'(1);
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_FINISH: begin
                    pass    <= (signature == GOLDEN_SIG);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    vec_idx <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench for c17_bist_ctrl: three instances (SETTLE=1/0/3) driven
// by a behavioural c17 with optional zero-response and fault modes.
module tb_c17_bist_ctrl;

    localparam logic [15:0] TB_POLY = 16'h1021;
    localparam logic [15:0] TB_SEED = 16'h0000;

    // mode 0 = real c17, mode 1 = responses tied low, mode 2 = N22 inverted on vector 13
    function automatic logic [1:0] c17_model(input logic [4:0] v);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
        n1  = v[0];
        n2  = v[1];
        n3  = v[2];
        n6  = v[3];
        n7  = v[4];
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [1:0] resp_model(input logic [4:0] v, input int mode);
        logic [1:0] r;
        r = c17_model(v);
        if (mode == 1) r = 2'b00;
        if (mode == 2 && v == 5'd13) r = r ^ 2'b01;
        return r;
    endfunction

    function automatic logic [15:0] model_sig(input int mode);
        logic [15:0] s;
        logic [1:0]  r;
        s = TB_SEED;
        for (int v = 0; v < 32; v++) begin
            r = resp_model(5'(v), mode);
            s = {s[14:0], 1'b0} ^ (s[15] ? TB_POLY : 16'h0000) ^ {14'b0, r};
        end
        return s;
    endfunction

    localparam logic [15:0] GOLDEN = model_sig(0);

    logic        clk;
    logic        rst;
    logic        start_r [3];
    logic [4:0]  vec_w   [3];
    logic [4:0]  idx_w   [3];
    logic [1:0]  resp_w  [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        pass_w  [3];
    logic [15:0] sig_w   [3];
    int          mode    [3];
    int          total;
    int          bad;
    int          nz;
    int          n;

    assign resp_w[0] = resp_model(vec_w[0], mode[0]);
    assign resp_w[1] = resp_model(vec_w[1], mode[1]);
    assign resp_w[2] = resp_model(vec_w[2], mode[2]);

    c17_bist_ctrl #(.SETTLE(1), .GOLDEN_SIG(GOLDEN)) dut (
        .clk(clk), .rst(rst), .start(start_r[0]), .vec_out(vec_w[0]),
        .resp_in(resp_w[0]), .vec_idx(idx_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .pass(pass_w[0]), .signature(sig_w[0])
    );

    c17_bist_ctrl #(.SETTLE(0), .GOLDEN_SIG(16'h0000)) dut_s0 (
        .clk(clk), .rst(rst), .start(start_r[1]), .vec_out(vec_w[1]),
        .resp_in(resp_w[1]), .vec_idx(idx_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .pass(pass_w[1]), .signature(sig_w[1])
    );

    c17_bist_ctrl #(.SETTLE(3), .GOLDEN_SIG(GOLDEN)) dut_s3 (
        .clk(clk), .rst(rst), .start(start_r[2]), .vec_out(vec_w[2]),
        .resp_in(resp_w[2]), .vec_idx(idx_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .pass(pass_w[2]), .signature(sig_w[2])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Starts one run, follows it to done, and checks latency plus the vector walk.
    task automatic applyStimulus(input int which, input int settle, input int latency,
                                 input int pulse_a, input int pulse_b, output int sig_nonzero);
        int         cycles;
        int         bad_steps;
        int         hold;
        logic [4:0] prev;
        @(negedge clk);
        start_r[which] = 1'b1;
        @(posedge clk);
        #1;
        start_r[which] = 1'b0;
        checkOutput("busy_on_start", 32'(busy_w[which]), 32'd1);
        checkOutput("done_clear_on_start", 32'(done_w[which]), 32'd0);
        cycles      = 0;
        bad_steps   = 0;
        sig_nonzero = 0;
        hold        = 1;
        prev        = vec_w[which];
        if (prev != 5'd0) bad_steps++;
        while (!done_w[which] && cycles < 400) begin
            start_r[which] = (cycles == pulse_a) || (cycles == pulse_b);
            @(posedge clk);
            #1;
            cycles++;
            if (sig_w[which] != 16'h0000) sig_nonzero++;
            if (idx_w[which] != vec_w[which]) bad_steps++;
            if (!done_w[which] && !busy_w[which]) bad_steps++;
            if (vec_w[which] == prev) begin
                hold++;
            end else begin
                if (prev == 5'd31) begin
                    if (vec_w[which] != 5'd0 || hold != settle + 3) bad_steps++;
                end else begin
                    if (vec_w[which] != prev + 5'd1 || hold != settle + 2) bad_steps++;
                end
                prev = vec_w[which];
                hold = 1;
            end
        end
        start_r[which] = 1'b0;
        checkOutput("done_latency", 32'(cycles), 32'(latency));
        checkOutput("vector_walk_errors", 32'(bad_steps), 32'd0);
        checkOutput("busy_low_at_done", 32'(busy_w[which]), 32'd0);
        checkOutput("vec_out_zero_at_done", 32'(vec_w[which]), 32'd0);
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            mode[i]    = 0;
        end
        repeat (2) @(negedge clk);
        checkOutput("reset_vec_out", 32'(vec_w[0]), 32'd0);
        checkOutput("reset_busy", 32'(busy_w[0]), 32'd0);
        checkOutput("reset_done", 32'(done_w[0]), 32'd0);
        checkOutput("reset_pass", 32'(pass_w[0]), 32'd0);
        checkOutput("reset_signature", 32'(sig_w[0]), 32'(TB_SEED));
        rst = 1'b0;

        $display("[TB] full c17 run, SETTLE=1");
        applyStimulus(0, 1, 97, -1, -1, nz);
        checkOutput("full_done", 32'(done_w[0]), 32'd1);
        checkOutput("full_pass", 32'(pass_w[0]), 32'd1);
        checkOutput("full_signature", 32'(sig_w[0]), 32'(GOLDEN));

        $display("[TB] start pulses at cycle 20 and during FINISH");
        applyStimulus(0, 1, 97, 20, 96, nz);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_reentry_busy", 32'(busy_w[0]), 32'd0);
        checkOutput("no_reentry_done", 32'(done_w[0]), 32'd1);
        checkOutput("no_reentry_vec", 32'(vec_w[0]), 32'd0);
        checkOutput("boundary_pass", 32'(pass_w[0]), 32'd1);

        $display("[TB] fault injection on vector 13");
        mode[0] = 2;
        applyStimulus(0, 1, 97, -1, -1, nz);
        checkOutput("fault_done", 32'(done_w[0]), 32'd1);
        checkOutput("fault_pass", 32'(pass_w[0]), 32'd0);
        checkOutput("fault_signature", 32'(sig_w[0]), 32'(model_sig(2)));
        checkOutput("fault_sig_differs", 32'(sig_w[0] != GOLDEN), 32'd1);
        mode[0] = 0;

        $display("[TB] responses tied low, SETTLE=0, golden zero");
        mode[1] = 1;
        applyStimulus(1, 0, 65, -1, -1, nz);
        checkOutput("zero_sig_nonzero_samples", 32'(nz), 32'd0);
        checkOutput("zero_pass", 32'(pass_w[1]), 32'd1);
        checkOutput("zero_signature", 32'(sig_w[1]), 32'd0);
        mode[1] = 0;

        $display("[TB] real c17, SETTLE=0 against golden zero");
        applyStimulus(1, 0, 65, -1, -1, nz);
        checkOutput("s0_signature", 32'(sig_w[1]), 32'(GOLDEN));
        checkOutput("s0_pass", 32'(pass_w[1]), 32'(GOLDEN == 16'h0000));

        $display("[TB] real c17, SETTLE=3");
        applyStimulus(2, 3, 161, -1, -1, nz);
        checkOutput("s3_pass", 32'(pass_w[2]), 32'd1);
        checkOutput("s3_signature", 32'(sig_w[2]), 32'(GOLDEN));

        $display("[TB] asynchronous reset at vector 10");
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        n = 0;
        while (vec_w[0] != 5'd10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reached_vec10", 32'(vec_w[0]), 32'd10);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_vec_out", 32'(vec_w[0]), 32'd0);
        checkOutput("async_rst_vec_idx", 32'(idx_w[0]), 32'd0);
        checkOutput("async_rst_busy", 32'(busy_w[0]), 32'd0);
        checkOutput("async_rst_done", 32'(done_w[0]), 32'd0);
        checkOutput("async_rst_pass", 32'(pass_w[0]), 32'd0);
        checkOutput("async_rst_signature", 32'(sig_w[0]), 32'(TB_SEED));
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1, 97, -1, -1, nz);
        checkOutput("post_rst_pass", 32'(pass_w[0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
